pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_capture_if.sv | 26 ++
 rtl/pwm_capture.sv | 140 ++++++++++++++
 tb/tb_pwm_capture.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Bundle of pwm_capture control inputs and measurement outputs.
// The master side drives enable/pwm_in and observes the results.
// The slave side is the capture block itself.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period;
  logic             valid;
  logic             timeout;
  logic             stuck_lvl;
  logic             busy;

  modport master (
    output enable, pwm_in,
    input  high_cnt, low_cnt, period, valid, timeout, stuck_lvl, busy
  );

  modport slave (
    input  enable, pwm_in,
    output high_cnt, low_cnt, period, valid, timeout, stuck_lvl, busy
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM input and measures the
// number of clk cycles spent high and low in each complete period.
// A period is closed by the rising edge that starts the next one; the
// results are published with a single-cycle valid pulse.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  pwm_capture_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       hc;
  logic [CNT_W-1:0]       lc;
  logic [CNT_W-1:0]       high_q;
  logic [CNT_W-1:0]       low_q;
  logic [CNT_W:0]         period_q;
  logic                   valid_q;
  logic                   timeout_q;
  logic                   stuck_q;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Synchroniser chain plus one extra delayed copy for edge detection.
  // Runs regardless of enable so edges are meaningful right after arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.pwm_in};
      s_d  <= s;
    end
  end

  // Measurement FSM: phase counters, result latching and timeout detection.
  // enable low overrides every state and wipes the published results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hc        <= '0;
      lc        <= '0;
      high_q    <= '0;
      low_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!bus.enable) begin
        state    <= IDLE;
        hc       <= '0;
        lc       <= '0;
        high_q   <= '0;
        low_q    <= '0;
        period_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            hc    <= '0;
            lc    <= '0;
            state <= ARM;
          end
          // A waveform already high when arming is skipped: only a fresh
          // rising edge starts a measurable period.
          ARM: begin
            if (rise) begin
              state <= HIGH;
              hc    <= {{(CNT_W-1){1'b0}}, 1'b1};
              lc    <= '0;
            end
          end
          // An edge in the saturation cycle takes priority over timeout.
          HIGH: begin
            if (fall) begin
              state <= LOW;
              lc    <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (hc == CNT_MAX) begin
              timeout_q <= 1'b1;
              stuck_q   <= s;
              state     <= ARM;
              hc        <= '0;
              lc        <= '0;
            end else begin
              hc <= hc + 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              high_q   <= hc;
              low_q    <= lc;
              period_q <= {1'b0, hc} + {1'b0, lc};
              valid_q  <= 1'b1;
              state    <= HIGH;
              hc       <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (lc == CNT_MAX) begin
              timeout_q <= 1'b1;
              stuck_q   <= s;
              state     <= ARM;
              hc        <= '0;
              lc        <= '0;
            end else begin
              lc <= lc + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.high_cnt  = high_q;
  assign bus.low_cnt   = low_q;
  assign bus.period    = period_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.stuck_lvl = stuck_q;
  assign bus.busy      = (state == HIGH) | (state == LOW);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8, SYNC_STAGES=2).
// A monitor records every valid pulse with its cycle stamp; each stimulus
// phase pushes the periods it drives and the recorded results are compared.
module tb_pwm_capture;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CW)) bus ();

  pwm_capture #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int h;
    int l;
    int reps;
    int eh;
    int el;
    int ep;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tmo_cnt = 0;
  int got_h[$], got_l[$], got_p[$], got_t[$];
  int exp_h[$], exp_l[$], exp_p[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every published result and count timeout pulses.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      got_h.push_back(int'(bus.high_cnt));
      got_l.push_back(int'(bus.low_cnt));
      got_p.push_back(int'(bus.period));
      got_t.push_back(cyc);
    end
    if (bus.timeout === 1'b1) tmo_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input logic lvl, input int n);
    bus.pwm_in = lvl;
    step(n);
  endtask

  task automatic expect_period(input int h, input int l, input int p);
    exp_h.push_back(h);
    exp_l.push_back(l);
    exp_p.push_back(p);
  endtask

  // Compare recorded valids against expectations; optionally check that
  // consecutive valids are spaced by the length of the later period.
  task automatic check_valids(input string tag, input bit gap);
    int n;
    chk({tag, "_count"}, got_h.size(), exp_h.size());
    n = (got_h.size() < exp_h.size()) ? got_h.size() : exp_h.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_high[%0d]", tag, k), got_h[k], exp_h[k]);
      chk($sformatf("%s_low[%0d]", tag, k), got_l[k], exp_l[k]);
      chk($sformatf("%s_period[%0d]", tag, k), got_p[k], exp_p[k]);
      if (gap && k > 0)
        chk($sformatf("%s_gap[%0d]", tag, k), got_t[k] - got_t[k-1], exp_p[k]);
    end
    got_h.delete(); got_l.delete(); got_p.delete(); got_t.delete();
    exp_h.delete(); exp_l.delete(); exp_p.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl = '{
      '{3, 5,   3, 3, 5,   8},
      '{1, 1,   2, 1, 1,   2},
      '{1, 200, 1, 1, 200, 201},
      '{2, 7,   1, 2, 7,   9},
      '{6, 1,   2, 6, 1,   7}
    };

    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    step(3);
    chk("rst_high", bus.high_cnt, 0);
    chk("rst_low", bus.low_cnt, 0);
    chk("rst_period", bus.period, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_stuck", bus.stuck_lvl, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    step(2);
    chk("idle_busy", bus.busy, 0);

    // Back-to-back periods from the table.
    bus.enable = 1'b1;
    step(3);
    chk("arm_busy", bus.busy, 0);
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        wave(1'b1, tbl[i].h);
        wave(1'b0, tbl[i].l);
        expect_period(tbl[i].eh, tbl[i].el, tbl[i].ep);
      end
    end
    wave(1'b1, 1);
    wave(1'b0, 6);
    check_valids("steady", 1'b1);
    chk("steady_no_timeout", tmo_cnt, 0);
    chk("mid_low_busy", bus.busy, 1);

    // Asynchronous reset mid-period: outputs clear before the next edge.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_high", bus.high_cnt, 0);
    chk("async_rst_period", bus.period, 0);
    chk("async_rst_busy", bus.busy, 0);
    step(2);
    reset = 1'b0;
    step(4);
    check_valids("post_reset", 1'b0);
    chk("post_reset_busy", bus.busy, 0);

    // Saturation: high phase held well past 255 cycles.
    wave(1'b1, 3);
    wave(1'b0, 5);
    expect_period(3, 5, 8);
    wave(1'b1, 300);
    chk("tmo_count", tmo_cnt, 1);
    chk("tmo_stuck", bus.stuck_lvl, 1);
    chk("tmo_keep_high", bus.high_cnt, 3);
    chk("tmo_keep_low", bus.low_cnt, 5);
    chk("tmo_keep_period", bus.period, 8);
    chk("tmo_arm_busy", bus.busy, 0);
    check_valids("pre_tmo", 1'b0);
    wave(1'b0, 4);
    wave(1'b1, 4);
    wave(1'b0, 4);
    wave(1'b1, 1);
    wave(1'b0, 4);
    expect_period(4, 4, 8);
    check_valids("post_tmo", 1'b0);
    chk("post_tmo_count", tmo_cnt, 1);

    // Enable drop mid-HIGH, then re-arm while the input is already high.
    bus.pwm_in = 1'b1;
    step(4);
    expect_period(1, 4, 5);
    check_valids("pre_drop", 1'b0);
    chk("pre_drop_busy", bus.busy, 1);
    bus.enable = 1'b0;
    step(1);
    chk("drop_busy", bus.busy, 0);
    chk("drop_high", bus.high_cnt, 0);
    chk("drop_low", bus.low_cnt, 0);
    chk("drop_period", bus.period, 0);
    step(2);
    bus.enable = 1'b1;
    step(5);
    chk("rearm_high_busy", bus.busy, 0);
    wave(1'b0, 3);
    wave(1'b1, 2);
    wave(1'b0, 4);
    wave(1'b1, 1);
    wave(1'b0, 4);
    expect_period(2, 4, 6);
    check_valids("rearm", 1'b0);
    chk("final_tmo_count", tmo_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
